// File: rtl/sample_sched_pkg.sv
// Shared types and helpers for the sample scheduler: FSM state encoding,
// default parameters and the round-robin pick function.
package sample_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        OUT
    } sched_state_e;

    localparam int DEF_N_REQ  = 4;
    localparam int DEF_W      = 1;
    localparam int DEF_SKEW_W = 3;

    // The pick function works on a fixed maximum width, so N_REQ is limited to MAX_REQ.
    localparam int MAX_REQ = 32;
    localparam int MAX_IDW = 5;

    typedef struct packed {
        logic               found;
        logic [MAX_IDW-1:0] idx;
    } rr_pick_t;

    // Search upward from rr with wrap at n; the first set request wins.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                         input logic [MAX_IDW-1:0] rr,
                                         input int                 n);
        rr_pick_t r;
        int       idx;
        r.found = 1'b0;
        r.idx   = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (i < n) begin
                idx = int'(rr) + i;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (!r.found && req[idx[MAX_IDW-1:0]]) begin
                    r.found = 1'b1;
                    r.idx   = idx[MAX_IDW-1:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sample_rr_arb.sv
// Round-robin arbiter: combinational winner selection from the registered
// pointer rr, which advances past the winner whenever a grant is taken.
module sample_rr_arb
    import sample_sched_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic                       update,
    output logic [$clog2(N_REQ)-1:0]   winner,
    output logic                       found
);

    localparam int IDW = $clog2(N_REQ);

    logic [IDW-1:0] rr;
    rr_pick_t       pick;
    logic           unused_pick;

    assign pick        = rr_pick(MAX_REQ'(req), MAX_IDW'(rr), N_REQ);
    assign winner      = pick.idx[IDW-1:0];
    assign found       = pick.found;
    assign unused_pick = ^pick.idx;

    // The granted requester drops to lowest priority on the next decision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr <= '0;
        end else if (update) begin
            rr <= (winner == IDW'(N_REQ - 1)) ? '0 : winner + 1'b1;
        end
    end

endmodule

// File: rtl/sample_scheduler.sv
// Shares one capture register among N_REQ requesters: round-robin grant,
// programmable skew wait, single capture of v, tagged output pulse.
module sample_scheduler
    import sample_sched_pkg::*;
#(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int W      = DEF_W,
    parameter int SKEW_W = DEF_SKEW_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [W-1:0]               v,
    input  logic [N_REQ-1:0]           req,
    input  logic [SKEW_W-1:0]          skew,
    output logic [N_REQ-1:0]           gnt,
    output logic                       smp_valid,
    output logic [W-1:0]               smp_data,
    output logic [$clog2(N_REQ)-1:0]   smp_id,
    output logic                       busy
);

    localparam int IDW = $clog2(N_REQ);

    sched_state_e      state;
    sched_state_e      state_nxt;
    logic [SKEW_W-1:0] cnt;
    logic [IDW-1:0]    id;
    logic [IDW-1:0]    winner;
    logic              found;
    logic              grant_now;

    assign grant_now = (state == IDLE) && found;
    assign busy      = (state != IDLE);

    sample_rr_arb #(
        .N_REQ(N_REQ)
    ) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .update(grant_now),
        .winner(winner),
        .found (found)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = WAIT;
            WAIT:    if (cnt == '0) state_nxt = OUT;
            OUT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // gnt and smp_valid default low each cycle so both are single-cycle pulses;
    // skew is only sampled at grant, so later changes cannot disturb the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt       <= '0;
            smp_valid <= 1'b0;
            smp_data  <= '0;
            smp_id    <= '0;
            cnt       <= '0;
            id        <= '0;
        end else begin
            gnt       <= '0;
            smp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        gnt <= N_REQ'(1) << winner;
                        id  <= winner;
                        cnt <= skew;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        smp_data  <= v;
                        smp_id    <= id;
                        smp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sample_scheduler.sv
// Self-checking bench for sample_scheduler: directed requests drive a
// scoreboard of expected samples that a monitor compares on smp_valid.
module tb_sample_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       v;
    logic [3:0] req;
    logic [2:0] skew;
    logic [3:0] gnt;
    logic       smp_valid;
    logic       smp_data;
    logic [1:0] smp_id;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit vtoggle = 1'b0;

    typedef struct {
        int id;
        int data;
        int cyc;
    } exp_t;

    exp_t sbq[$];

    sample_scheduler #(
        .N_REQ (4),
        .W     (1),
        .SKEW_W(3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .v        (v),
        .req      (req),
        .skew     (skew),
        .gnt      (gnt),
        .smp_valid(smp_valid),
        .smp_data (smp_data),
        .smp_id   (smp_id),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // cyc holds the index of the most recent rising edge.
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (vtoggle) v = cyc[0];
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic pushExp(input int id, input int data, input int c);
        exp_t e;
        e.id   = id;
        e.data = data;
        e.cyc  = c;
        sbq.push_back(e);
    endtask

    task automatic waitGnt(output logic [3:0] g, output int c);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (gnt == 4'b0000 && n < 20);
        g = gnt;
        c = cyc;
        if (gnt == 4'b0000) checkOutput("gnt timeout", 32'd0, 32'd1);
    endtask

    task automatic waitDrain();
        int n = 0;
        while (sbq.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) checkOutput("drain timeout", 32'(sbq.size()), 32'd0);
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [2:0] s, input logic vv,
                                 input bit hold, output logic [3:0] g, output int c);
        req  = r;
        skew = s;
        if (!vtoggle) v = vv;
        waitGnt(g, c);
        if (!hold) req = 4'b0000;
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, " gnt"}, 32'(gnt), 32'd0);
        checkOutput({tag, " smp_valid"}, 32'(smp_valid), 32'd0);
        checkOutput({tag, " smp_data"}, 32'(smp_data), 32'd0);
        checkOutput({tag, " smp_id"}, 32'(smp_id), 32'd0);
        checkOutput({tag, " busy"}, 32'(busy), 32'd0);
    endtask

    // Monitor: every sample pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && smp_valid) begin
            if (sbq.size() == 0) begin
                checkOutput("unexpected smp_valid", 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                checkOutput("smp_id", 32'(smp_id), e.id);
                checkOutput("smp_data", 32'(smp_data), e.data);
                checkOutput("valid cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #20000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [3:0] g;
        int         c0;
        int         last;

        rst  = 1'b1;
        req  = 4'b0000;
        skew = 3'd0;
        v    = 1'b0;
        repeat (2) @(negedge clk);
        checkIdleOutputs("power-on reset");
        rst = 1'b0;
        @(negedge clk);

        // single request, skew 0
        applyStimulus(4'b0100, 3'd0, 1'b1, 1'b0, g, c0);
        checkOutput("single gnt", 32'(g), 32'h4);
        checkOutput("single busy E0", 32'(busy), 32'd1);
        pushExp(2, 1, c0 + 1);
        @(negedge clk);
        checkOutput("single gnt pulse", 32'(gnt), 32'd0);
        checkOutput("single busy E1", 32'(busy), 32'd1);
        @(negedge clk);
        checkOutput("single busy E2", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);

        // skew 5 with v toggling each cycle; pointer is at 3 so requester 0 wraps in
        vtoggle = 1'b1;
        applyStimulus(4'b0001, 3'd5, 1'b0, 1'b0, g, c0);
        checkOutput("skew5 gnt", 32'(g), 32'h1);
        pushExp(0, (c0 + 5) & 1, c0 + 6);
        waitDrain();
        vtoggle = 1'b0;

        // mid-simulation reset with every requester asking
        rst  = 1'b1;
        req  = 4'b1111;
        skew = 3'd0;
        v    = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checkIdleOutputs("reset held");
        end
        rst = 1'b0;

        // fairness: held requests rotate 0,1,2,3,0,1 with one grant per 3 cycles
        last = 0;
        for (int k = 0; k < 6; k++) begin
            waitGnt(g, c0);
            checkOutput("fair gnt", 32'(g), 32'(4'b0001 << (k % 4)));
            if (k > 0) checkOutput("fair spacing", c0 - last, 32'd3);
            last = c0;
            v = ~v;
            pushExp(k % 4, int'(v), c0 + 1);
            if (k == 5) req = 4'b0000;
        end
        waitDrain();
        repeat (2) @(negedge clk);

        // skew change during WAIT must not move the capture edge
        applyStimulus(4'b1000, 3'd4, 1'b1, 1'b0, g, c0);
        checkOutput("skewchg gnt", 32'(g), 32'h8);
        skew = 3'd0;
        pushExp(3, 1, c0 + 5);
        waitDrain();
        repeat (2) @(negedge clk);

        // reset mid-WAIT: pointer returns to 0, so requester 1 wins again
        applyStimulus(4'b0110, 3'd6, 1'b1, 1'b1, g, c0);
        checkOutput("abort gnt", 32'(g), 32'h2);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("abort async valid", 32'(smp_valid), 32'd0);
        checkOutput("abort async busy", 32'(busy), 32'd0);
        repeat (2) begin
            @(negedge clk);
            checkOutput("abort held gnt", 32'(gnt), 32'd0);
            checkOutput("abort held busy", 32'(busy), 32'd0);
        end
        rst = 1'b0;
        v   = 1'b0;
        waitGnt(g, c0);
        checkOutput("regrant gnt", 32'(g), 32'h2);
        req = 4'b0000;
        pushExp(1, 0, c0 + 7);
        waitDrain();

        repeat (3) @(negedge clk);
        checkOutput("scoreboard empty", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
